// File: rtl/bitsim_column_feeder.sv
// Upstream feeder for the bit-serial precompute MAC: captures one operand vector,
// precomputes pairwise activation sums and streams weight bit-columns LSB-first.
module bitsim_column_feeder #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned VEC_LENGTH    = 8,
    parameter int unsigned SKIP_ZERO_COL = 1,
    parameter int unsigned IDX_WIDTH     = $clog2(DATA_WIDTH)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  act_in,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  w_in,
    input  logic                                   out_ready,
    output logic                                   en,
    output logic                                   load_accum,
    output logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  act_out,
    output logic [VEC_LENGTH/2-1:0][DATA_WIDTH:0]  act_psum_out,
    output logic [VEC_LENGTH-1:0]                  w_bit,
    output logic [IDX_WIDTH-1:0]                   column_idx,
    output logic                                   is_msb,
    output logic                                   vec_done,
    output logic                                   busy
);

    localparam int unsigned NUM_PAIRS  = VEC_LENGTH / 2;
    localparam int unsigned PSUM_WIDTH = DATA_WIDTH + 1;
    localparam bit          SKIP       = (SKIP_ZERO_COL != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_q, w_q;
    logic [NUM_PAIRS-1:0][PSUM_WIDTH-1:0]  psum_q, psum_c;
    logic [IDX_WIDTH-1:0]                  col_q, cap_col, nxt_col;
    logic [DATA_WIDTH-1:0]                 pend_q, nz_mask, issue_mask, cap_pend, nxt_pend;
    logic                                  first_q, la_q, vd_q;
    logic                                  streaming, last_col, capture;

    function automatic logic [IDX_WIDTH-1:0] lowest_bit(input logic [DATA_WIDTH-1:0] m);
        lowest_bit = '0;
        for (int c = int'(DATA_WIDTH) - 1; c >= 0; c--) begin
            if (m[c]) lowest_bit = IDX_WIDTH'(c);
        end
    endfunction

    // Columns to issue for the vector on the input bus; an all-zero vector still gets column 0.
    always_comb begin
        nz_mask = '0;
        for (int i = 0; i < int'(VEC_LENGTH); i++) nz_mask |= w_in[i];
        if (SKIP) issue_mask = (nz_mask == '0) ? DATA_WIDTH'(1) : nz_mask;
        else      issue_mask = '1;
        cap_col  = lowest_bit(issue_mask);
        cap_pend = issue_mask & ~(DATA_WIDTH'(1) << cap_col);
        nxt_col  = lowest_bit(pend_q);
        nxt_pend = pend_q & ~(DATA_WIDTH'(1) << nxt_col);
    end

    always_comb begin
        for (int j = 0; j < int'(NUM_PAIRS); j++) begin
            psum_c[j] = PSUM_WIDTH'($signed(act_in[2*j])) + PSUM_WIDTH'($signed(act_in[2*j+1]));
        end
    end

    assign streaming = (state_q == S_STREAM);
    assign last_col  = (pend_q == '0);
    assign busy      = (state_q != S_IDLE);
    assign en        = busy && out_ready;
    assign in_ready  = (state_q == S_IDLE) || (streaming && last_col && out_ready);
    assign capture   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_valid) state_d = S_STREAM;
            S_STREAM: if (en && last_col) state_d = in_valid ? S_STREAM : S_DRAIN;
            S_DRAIN:  if (en) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Operand capture, column pointer and the one-beat-delayed MAC controls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_q   <= '0;
            w_q     <= '0;
            psum_q  <= '0;
            col_q   <= '0;
            pend_q  <= '0;
            first_q <= 1'b0;
            la_q    <= 1'b0;
            vd_q    <= 1'b0;
        end else begin
            if (capture) begin
                act_q   <= act_in;
                w_q     <= w_in;
                psum_q  <= psum_c;
                col_q   <= cap_col;
                pend_q  <= cap_pend;
                first_q <= 1'b1;
            end else if (en && streaming) begin
                col_q   <= nxt_col;
                pend_q  <= nxt_pend;
                first_q <= 1'b0;
            end
            if (en) begin
                la_q <= streaming && first_q;
                vd_q <= streaming && last_col;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(VEC_LENGTH); i++) begin
            w_bit[i] = streaming ? w_q[i][col_q] : 1'b0;
        end
        column_idx = streaming ? col_q : '0;
        is_msb     = streaming && (col_q == IDX_WIDTH'(DATA_WIDTH - 1));
    end

    assign load_accum   = la_q;
    assign vec_done     = vd_q;
    assign act_out      = act_q;
    assign act_psum_out = psum_q;

endmodule

// File: tb/tb_bitsim_column_feeder.sv
// Bench for bitsim_column_feeder: directed table rows, hand-built corner sequences and
// random bursts checked against a column-list model with a downstream MAC model.
module tb_bitsim_column_feeder;

    localparam int unsigned DW = 8;
    localparam int unsigned VL = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned PW = DW + 1;

    typedef logic [VL-1:0][DW-1:0]   vec_t;
    typedef logic [VL/2-1:0][DW:0]   psum_t;
    typedef struct {
        logic [VL-1:0] wb;
        int            idx;
        bit            first;
        bit            last;
        bit            drain;
        bit            la;
        bit            vd;
    } beat_t;
    typedef struct {
        vec_t   act;
        vec_t   w;
        int     beats;
        longint sum;
    } row_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    vec_t          act_in = '0;
    vec_t          w_in = '0;
    logic          in_ready, en, load_accum, is_msb, vec_done, busy;
    vec_t          act_out;
    psum_t         act_psum_out;
    logic [VL-1:0] w_bit;
    logic [IW-1:0] column_idx;

    bitsim_column_feeder #(
        .DATA_WIDTH(DW), .VEC_LENGTH(VL), .SKIP_ZERO_COL(1), .IDX_WIDTH(IW)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .act_in(act_in), .w_in(w_in), .out_ready(out_ready), .en(en),
        .load_accum(load_accum), .act_out(act_out), .act_psum_out(act_psum_out),
        .w_bit(w_bit), .column_idx(column_idx), .is_msb(is_msb),
        .vec_done(vec_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int     n_total = 0;
    int     n_pass = 0;
    beat_t  exp_q[$];
    longint sum_q[$];
    longint done_sums[$];
    vec_t   pend_act[$];
    vec_t   pend_w[$];
    bit     rdy_pat[$];
    vec_t   exp_act = '0;
    int     beat_cnt = 0;
    bit     hs_flag = 1'b0;
    int     rdy_pct = 100;
    longint acc = 0;
    longint stage = 0;
    row_t   rows[4];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        else n_pass++;
    endtask

    task automatic fail_now(input string nm);
        n_total++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    function automatic longint dot(input vec_t a, input vec_t w);
        longint s = 0;
        for (int i = 0; i < int'(VL); i++) s += longint'($signed(a[i])) * longint'($signed(w[i]));
        return s;
    endfunction

    function automatic psum_t psum_of(input vec_t a);
        psum_t p;
        for (int j = 0; j < int'(VL/2); j++) p[j] = PW'(int'($signed(a[2*j])) + int'($signed(a[2*j+1])));
        return p;
    endfunction

    // Expected beat list of one vector: every nonzero column ascending, or column 0 alone.
    function automatic void push_vector(input vec_t a, input vec_t w, input bit cf, input bit cl);
        logic [DW-1:0] z = '0;
        int cols[$];
        for (int i = 0; i < int'(VL); i++) z |= w[i];
        for (int c = 0; c < int'(DW); c++) if (z[c]) cols.push_back(c);
        if (cols.size() == 0) cols.push_back(0);
        foreach (cols[k]) begin
            beat_t b;
            for (int i = 0; i < int'(VL); i++) b.wb[i] = w[i][cols[k]];
            b.idx   = cols[k];
            b.first = (k == 0);
            b.last  = (k == cols.size() - 1);
            b.drain = 1'b0;
            b.la    = (k == 0) ? cf : (k == 1);
            b.vd    = (k == 0) ? cl : 1'b0;
            exp_q.push_back(b);
        end
        sum_q.push_back(dot(a, w));
    endfunction

    task automatic monitor_step();
        bit     idle, rdy_exp, hs, cf, cl;
        beat_t  b, d;
        longint c;
        idle    = (exp_q.size() == 0);
        rdy_exp = idle ? 1'b1 : (exp_q[0].last && out_ready);
        chk("busy", 64'(busy), 64'(!idle));
        chk("in_ready", 64'(in_ready), 64'(rdy_exp));
        chk("en", 64'(en), 64'(!idle && out_ready));
        if (idle) begin
            chk("idle_outputs", 64'({w_bit, column_idx, is_msb, load_accum, vec_done}), 64'(0));
        end else begin
            b = exp_q[0];
            chk("w_bit", 64'(w_bit), 64'(b.wb));
            chk("column_idx", 64'(column_idx), 64'(b.idx));
            chk("is_msb", 64'(is_msb), 64'(!b.drain && b.idx == int'(DW) - 1));
            chk("load_accum", 64'(load_accum), 64'(b.la));
            chk("vec_done", 64'(vec_done), 64'(b.vd));
            chk("act_out", 64'(act_out), 64'(exp_act));
            chk("act_psum_out", 64'(act_psum_out), 64'(psum_of(exp_act)));
        end
        hs = in_valid && rdy_exp;
        cf = 1'b0;
        cl = 1'b0;
        if (!idle && out_ready) begin
            b = exp_q.pop_front();
            beat_cnt++;
            c = 0;
            for (int i = 0; i < int'(VL); i++) if (w_bit[i]) c += longint'($signed(act_out[i]));
            c = c <<< column_idx;
            if (is_msb) c = -c;
            if (b.la) acc = stage;
            else      acc = acc + stage;
            stage = c;
            if (b.vd) begin
                if (sum_q.size() == 0) fail_now("vec_done_without_vector");
                else chk("mac_sum", 64'(acc), 64'(sum_q.pop_front()));
                done_sums.push_back(acc);
            end
            if (!b.drain) begin
                cf = b.first;
                cl = b.last;
            end
            if (b.last && !b.drain && !hs) begin
                d.wb = '0; d.idx = 0; d.first = 1'b0; d.last = 1'b0;
                d.drain = 1'b1; d.la = b.first; d.vd = 1'b1;
                exp_q.push_back(d);
            end
        end
        if (hs) begin
            push_vector(act_in, w_in, cf, cl);
            exp_act = act_in;
        end
        hs_flag = hs;
    endtask

    always @(negedge clk) begin
        if (!reset) monitor_step();
    end

    task automatic feed(input int max_cycles);
        int n = 0;
        while ((pend_act.size() != 0 || exp_q.size() != 0) && n < max_cycles) begin
            if (pend_act.size() != 0) begin
                in_valid = 1'b1;
                act_in   = pend_act[0];
                w_in     = pend_w[0];
            end else begin
                in_valid = 1'b0;
            end
            if (rdy_pat.size() != 0) out_ready = rdy_pat.pop_front();
            else out_ready = ($urandom_range(99) < rdy_pct);
            @(posedge clk); #1;
            n++;
            if (hs_flag) begin
                void'(pend_act.pop_front());
                void'(pend_w.pop_front());
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (n >= max_cycles) fail_now("feed_timeout");
    endtask

    task automatic run_row(input string nm, input vec_t a, input vec_t w, input int beats, input longint sum);
        int base = beat_cnt;
        int nd = done_sums.size();
        pend_act.push_back(a);
        pend_w.push_back(w);
        feed(400);
        chk({nm, "_beats"}, 64'(beat_cnt - base), 64'(beats));
        if (done_sums.size() == nd + 1) chk({nm, "_sum"}, 64'(done_sums[nd]), 64'(sum));
        else fail_now({nm, "_vec_done_count"});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  a, w, one, seq;
        psum_t p;
        int    base, nd, n, nvec;

        for (int i = 0; i < int'(VL); i++) begin
            seq[i] = DW'(i + 1);
            one[i] = DW'(1);
        end
        rows[0] = '{act: seq, w: {VL{8'hFF}}, beats: 9, sum: -36};
        rows[1] = '{act: seq, w: {VL{8'h04}}, beats: 2, sum: 144};
        rows[2] = '{act: seq, w: {VL{8'h00}}, beats: 2, sum: 0};
        rows[3] = '{act: one, w: {VL{8'h81}}, beats: 3, sum: -1016};

        #12;
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_outputs", 64'({en, load_accum, is_msb, vec_done, busy, w_bit, column_idx}), 64'(0));
        chk("reset_operands", 64'(act_out), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (rows[r]) begin
            run_row($sformatf("row%0d", r), rows[r].act, rows[r].w, rows[r].beats, rows[r].sum);
            if (r == 0) begin
                p[0] = PW'(3); p[1] = PW'(7); p[2] = PW'(11); p[3] = PW'(15);
                chk("psum_held", 64'(act_psum_out), 64'(p));
            end
        end

        // Back-to-back vectors: no drain beat between them.
        base = beat_cnt;
        nd = done_sums.size();
        pend_act.push_back(one); pend_w.push_back({VL{8'h01}});
        pend_act.push_back(one); pend_w.push_back({VL{8'h81}});
        feed(400);
        chk("b2b_beats", 64'(beat_cnt - base), 64'(4));
        if (done_sums.size() == nd + 2) begin
            chk("b2b_sum_a", 64'(done_sums[nd]), 64'(8));
            chk("b2b_sum_b", 64'(done_sums[nd+1]), 64'(-1016));
        end else fail_now("b2b_vec_done_count");

        // Mid-stream stall: outputs hold while out_ready is low.
        rdy_pat = '{1, 1, 1, 0, 0, 1};
        run_row("stall", seq, {VL{8'hFF}}, 9, -36);

        // Reset on the fourth beat abandons the vector.
        base = beat_cnt;
        nd = done_sums.size();
        in_valid = 1'b1; act_in = seq; w_in = {VL{8'hFF}}; out_ready = 1'b1;
        n = 0;
        while (beat_cnt - base < 3 && n < 50) begin
            @(posedge clk); #1;
            n++;
            if (hs_flag) in_valid = 1'b0;
        end
        if (n >= 50) fail_now("reset_seq_timeout");
        chk("pre_reset_busy", 64'(busy), 64'(1));
        reset = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        chk("midrst_outputs", 64'({en, load_accum, is_msb, vec_done, busy, w_bit, column_idx}), 64'(0));
        chk("midrst_operands", 64'(act_out), 64'(0));
        chk("midrst_psum", 64'(act_psum_out), 64'(0));
        exp_q.delete();
        sum_q.delete();
        exp_act = '0;
        hs_flag = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_no_vec_done", 64'(done_sums.size()), 64'(nd));
        run_row("after_reset", seq, {VL{8'hFF}}, 9, -36);

        // Random bursts with random backpressure and column sparsity.
        rdy_pct = 70;
        nd = done_sums.size();
        nvec = 0;
        repeat (12) begin
            int nb;
            nb = $urandom_range(1, 4);
            repeat (nb) begin
                logic [DW-1:0] cm;
                cm = ($urandom_range(3) == 0) ? '0 : DW'($urandom);
                for (int i = 0; i < int'(VL); i++) begin
                    a[i] = DW'($urandom);
                    w[i] = DW'($urandom) & cm;
                end
                pend_act.push_back(a);
                pend_w.push_back(w);
                nvec++;
            end
            feed(3000);
        end
        chk("random_vec_count", 64'(done_sums.size() - nd), 64'(nvec));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bitsim_column_feeder.md
Name: bitsim_column_feeder

Overview:
- Upstream feeder for the bit-serial precompute MAC.
- Accepts one vector per handshake: VEC_LENGTH signed activations plus VEC_LENGTH signed weights.
- Registers the operands and precomputes the pairwise activation sums.
- Streams weight bit-columns LSB-first, one per beat, with the matching column_idx, is_msb, en and load_accum controls. These outputs drive the MAC directly.
- Optionally skips all-zero bit-columns to exploit bit-level sparsity.

Parameters:
DATA_WIDTH, 8, activation/weight width; also the number of bit-columns per vector.
VEC_LENGTH, 8, vector length; must be even.
SKIP_ZERO_COL, 1, 1 = skip columns whose weight bits are all zero; 0 = always issue every column.
IDX_WIDTH, $clog2(DATA_WIDTH), width of column_idx.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  feeder can accept a vector this cycle
act_in  in  DATA_WIDTH x VEC_LENGTH  signed activations
w_in  in  DATA_WIDTH x VEC_LENGTH  signed weights, two's complement
out_ready  in  1  MAC may advance this cycle
en  out  1  beat strobe to MAC (a beat occurs when en=1)
load_accum  out  1  MAC accumulator loads accum_prev instead of self-accumulating
act_out  out  DATA_WIDTH x VEC_LENGTH  registered activations
act_psum_out  out  (DATA_WIDTH+1) x VEC_LENGTH/2  act[2j]+act[2j+1], sign-extended
w_bit  out  VEC_LENGTH  bit column_idx of each weight
column_idx  out  IDX_WIDTH  current bit position
is_msb  out  1  column_idx == DATA_WIDTH-1
vec_done  out  1  one-cycle pulse; the MAC accumulator holds the vector's final sum after this edge
busy  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE. All outputs 0 except in_ready=1. Operand registers and pending flags are cleared. A reset mid-stream abandons the vector; no vec_done is issued.
- States:
  - IDLE: in_ready=1, en=0. in_valid captures operands and psums and goes to STREAM; the first column is valid on the next cycle.
  - STREAM: en = out_ready. Column pointer col holds the current column.
  - DRAIN: one beat of en = out_ready, w_bit=0, is_msb=0, column_idx=0; then IDLE.
- Column selection:
  - Capture computes the nonzero-column mask Z (bit c = OR over w_in[i][c]).
  - With SKIP_ZERO_COL=1, first col = lowest set bit of Z, and each beat advances to the next higher set bit.
  - If Z==0, exactly one beat is issued at column 0 with w_bit=0.
  - With SKIP_ZERO_COL=0, cols run 0..DATA_WIDTH-1.
- Beat semantics: a beat occurs when en=1 (out_ready=1). If out_ready=0, all outputs hold and col does not advance.
- load_accum alignment: the MAC has one register stage between column input and accumulator. load_accum is therefore asserted on the beat immediately after the beat that issued a vector's first column. That beat belongs to the next column, the next vector, or DRAIN.
- Last column accepted:
  - If in_valid=1 and in_ready=1 in the same cycle, the new vector is captured and the next beat is its first column, so back-to-back vectors have no bubble. in_ready is asserted combinationally during the last-column beat when out_ready=1.
  - Otherwise the feeder goes to DRAIN.
- vec_done pulses on the beat that follows a vector's last-column beat. That beat is the next vector's first beat or DRAIN.
- Arithmetic: act_psum_out is a DATA_WIDTH+1 signed sum, so no overflow is possible; it is computed at capture and held.
- is_msb marks the negatively weighted two's-complement column.
- Simultaneous last beat, new in_valid, and a single-column vector: load_accum and vec_done are both asserted on the following beat.

Test Plan:
- act=1..8, w all 0xFF, SKIP=1 -> 8 beats, idx 0..7, is_msb only on idx 7. psum=3,7,11,15. load_accum on beat 2; vec_done on DRAIN. MAC sum = -36.
- act=1..8, w all 0x04 -> single beat at idx 2, w_bit=0xFF. Then DRAIN with load_accum=1 and vec_done=1. MAC sum = 144.
- w all 0x00, SKIP=1 -> one beat idx 0, w_bit=0, then DRAIN. MAC sum = 0.
- Two vectors back-to-back (w=0x01 then w=0x81, act=1) -> no bubble. Second vector is idx 0 then idx 7. vec_done for vector A and load_accum for vector B coincide. Sums 8 and -1016.
- out_ready toggled 1,0,0,1 mid-stream -> en follows out_ready. All outputs and col frozen while en=0. Final sum unchanged (-36 case).
- Assert reset at beat 3 of the -36 case -> outputs 0 immediately, in_ready=1, no vec_done. A new vector afterwards completes normally.
